pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, width of every PC/target bus.
REQ-002 SHALL have parameter RESET_PC, default 32'h8000_0000, first fetch address after reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-004 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- DD_trap_i  in  1  ecall/exception redirect request
- DD_trap_target_i  in  PC_WIDTH  trap vector
- DD_mret_i  in  1  mret redirect request
- DD_mret_target_i  in  PC_WIDTH  saved mepc
- DD_mispred_i  in  1  branch train valid and mispredicted
- DD_jalr_i  in  1  jalr resolved
- DD_jmp_i  in  PC_WIDTH  corrected target for mispredict/jalr
- F_ready_i  in  1  fetch stage accepts F_PC_o this cycle
- F_pred_taken_i  in  1  predictor hint for F_PC_o: taken
- F_pred_target_i  in  PC_WIDTH  predicted target
- F_is_call_i  in  1  predecode: F_PC_o is a call
- F_is_ret_i  in  1  predecode: F_PC_o is a return
- F_PC_o  out  PC_WIDTH  current fetch PC (registered)
- F_valid_o  out  1  F_PC_o is valid
- F_ras_count_o  out  clog2(RAS_DEPTH)+1  RAS occupancy

Function
REQ-005 SHALL define accept = F_valid_o & F_ready_i; hint inputs SHALL be ignored unless accept.
REQ-006 SHALL compute next PC by fixed priority: DD_trap_i -> DD_trap_target_i; DD_mret_i -> DD_mret_target_i; DD_mispred_i -> DD_jmp_i; DD_jalr_i -> DD_jmp_i; accept & F_is_ret_i & RAS non-empty -> RAS top; accept & F_pred_taken_i -> F_pred_target_i; accept -> F_PC_o+4; else hold.
REQ-007 SHALL load any redirect into F_PC_o on the next rising edge irrespective of F_ready_i (one-cycle latency).
REQ-008 SHALL apply no RAS push/pop in a cycle with any redirect asserted.
REQ-009 SHALL, on accept & F_is_call_i, push F_PC_o+4; when full, overwrite the oldest entry (circular), count stays RAS_DEPTH.
REQ-010 SHALL, on accept & F_is_ret_i with RAS empty, predict per remaining priority (taken hint or PC+4), count stays 0.
REQ-011 SHALL, on accept with call and ret both set, use old top as target, then replace top with F_PC_o+4; count unchanged (pop-then-push).
REQ-012 SHALL, on DD_trap_i, clear RAS count to 0; other redirects SHALL leave RAS untouched.
REQ-013 SHALL compute PC+4 modulo 2^PC_WIDTH (wrap, no overflow flag); targets used unmodified.
REQ-014 SHALL keep F_valid_o high from the first edge after reset release onward.

Reset
REQ-015 SHALL, while rst_n low, force F_PC_o=RESET_PC, F_valid_o=0, F_ras_count_o=0 asynchronously.
REQ-016 SHALL, on the first edge after rst_n rises, set F_valid_o=1 with F_PC_o=RESET_PC; redirects on that edge SHALL be ignored.
REQ-017 SHALL abandon any in-flight redirect or RAS update when reset asserts mid-operation; RAS entry contents need not be cleared.

Configuration
REQ-018 SHALL compile the RAS only when macro PC_GEN_RAS_EN is defined.
REQ-019 SHALL, without PC_GEN_RAS_EN, treat F_is_call_i/F_is_ret_i as don't-care, hold F_ras_count_o=0, and infer no RAS storage; returns fall to taken-hint/PC+4 and are fixed by DD_jalr_i.

Verification
REQ-020 Reset release, F_ready_i=1 for 3 cycles -> F_PC_o 8000_0000, 8000_0004, 8000_0008; F_valid_o=0 during reset.
REQ-021 F_ready_i=0, DD_mispred_i=1, DD_jmp_i=8000_0100 plus DD_trap_i=1, target 8000_0040 same cycle -> next F_PC_o=8000_0040, RAS count 0.
REQ-022 With PC_GEN_RAS_EN: call at 8000_0010 accepted, then ret at 8000_0200 accepted -> F_PC_o=8000_0014, count 1 then 0.
REQ-023 With PC_GEN_RAS_EN, RAS_DEPTH=4: 5 calls then 5 rets -> first 4 rets return newest-first, 5th ret falls through to PC+4, count never exceeds 4.
REQ-024 F_PC_o=FFFF_FFFC accepted, no hints -> next F_PC_o=0000_0000.
REQ-025 F_ready_i=0 for 4 cycles, no redirect -> F_PC_o and RAS unchanged; call/ret hints ignored.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised redirect/prediction mux feeding a registered fetch PC.
// Optional return-address stack compiled in with macro PC_GEN_RAS_EN (default build: no RAS).
module pc_gen #(
  parameter int                     PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]    RESET_PC  = 32'h8000_0000,
  parameter int                     RAS_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          DD_trap_i,
  input  logic [PC_WIDTH-1:0]           DD_trap_target_i,
  input  logic                          DD_mret_i,
  input  logic [PC_WIDTH-1:0]           DD_mret_target_i,
  input  logic                          DD_mispred_i,
  input  logic                          DD_jalr_i,
  input  logic [PC_WIDTH-1:0]           DD_jmp_i,
  input  logic                          F_ready_i,
  input  logic                          F_pred_taken_i,
  input  logic [PC_WIDTH-1:0]           F_pred_target_i,
  input  logic                          F_is_call_i,
  input  logic                          F_is_ret_i,
  output logic [PC_WIDTH-1:0]           F_PC_o,
  output logic                          F_valid_o,
  output logic [$clog2(RAS_DEPTH):0]    F_ras_count_o
);

  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                valid_q, valid_d;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                accept;
  logic                redirect;
  logic                ras_hit;
  logic [PC_WIDTH-1:0] ras_top;
  logic [CW-1:0]       ras_count;

  assign accept   = valid_q & F_ready_i;
  assign redirect = DD_trap_i | DD_mret_i | DD_mispred_i | DD_jalr_i;
  assign pc_plus4 = pc_q + PC_WIDTH'(4);

`ifdef PC_GEN_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]       top_q, top_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                wr_en;
  logic [PW-1:0]       wr_idx;
  logic                ras_nonempty;
  logic                do_call;
  logic                do_ret;

  assign ras_nonempty = (cnt_q != '0);
  assign ras_top      = ras_q[top_q];
  assign ras_hit      = F_is_ret_i & ras_nonempty;
  assign do_call      = accept & ~redirect & F_is_call_i;
  assign do_ret       = accept & ~redirect & F_is_ret_i & ras_nonempty;

  // top_q always points at the newest entry; a push into a full stack wraps onto the oldest
  always_comb begin
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = top_q;
    if (valid_q && DD_trap_i) begin
      cnt_d = '0;
    end else if (do_ret && do_call) begin
      wr_en = 1'b1;
    end else if (do_ret) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end else if (do_call) begin
      top_d  = top_q + PW'(1);
      wr_idx = top_q + PW'(1);
      wr_en  = 1'b1;
      if (cnt_q != CW'(RAS_DEPTH)) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry contents are meaningless while the count says empty, so they carry no reset
  always_ff @(posedge clk) begin
    if (wr_en && rst_n) begin
      ras_q[wr_idx] <= pc_plus4;
    end
  end

  assign ras_count = cnt_q;
`else
  logic unused_ras_hints;

  assign unused_ras_hints = F_is_call_i ^ F_is_ret_i;
  assign ras_hit          = 1'b0;
  assign ras_top          = '0;
  assign ras_count        = '0;
`endif

  // The first edge after reset only raises valid; the reset PC is fetched before any redirect
  always_comb begin
    valid_d = 1'b1;
    pc_d    = pc_q;
    if (valid_q) begin
      if (DD_trap_i) begin
        pc_d = DD_trap_target_i;
      end else if (DD_mret_i) begin
        pc_d = DD_mret_target_i;
      end else if (DD_mispred_i || DD_jalr_i) begin
        pc_d = DD_jmp_i;
      end else if (accept && ras_hit) begin
        pc_d = ras_top;
      end else if (accept && F_pred_taken_i) begin
        pc_d = F_pred_target_i;
      end else if (accept) begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign F_PC_o        = pc_q;
  assign F_valid_o     = valid_q;
  assign F_ras_count_o = ras_count;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed steps plus random traffic against a queue-based
// reference model; follows PC_GEN_RAS_EN the same way the design does.
module tb_pc_gen;
  localparam int          W   = 32;
  localparam int          D   = 4;
  localparam logic [31:0] RST = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        DD_trap_i, DD_mret_i, DD_mispred_i, DD_jalr_i;
  logic [31:0] DD_trap_target_i, DD_mret_target_i, DD_jmp_i;
  logic        F_ready_i, F_pred_taken_i, F_is_call_i, F_is_ret_i;
  logic [31:0] F_pred_target_i;
  logic [31:0] F_PC_o;
  logic        F_valid_o;
  logic [2:0]  F_ras_count_o;

  pc_gen #(.PC_WIDTH(W), .RESET_PC(RST), .RAS_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .DD_trap_i(DD_trap_i), .DD_trap_target_i(DD_trap_target_i),
    .DD_mret_i(DD_mret_i), .DD_mret_target_i(DD_mret_target_i),
    .DD_mispred_i(DD_mispred_i), .DD_jalr_i(DD_jalr_i), .DD_jmp_i(DD_jmp_i),
    .F_ready_i(F_ready_i), .F_pred_taken_i(F_pred_taken_i), .F_pred_target_i(F_pred_target_i),
    .F_is_call_i(F_is_call_i), .F_is_ret_i(F_is_ret_i),
    .F_PC_o(F_PC_o), .F_valid_o(F_valid_o), .F_ras_count_o(F_ras_count_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: fetch PC, valid flag and the return stack as a bounded queue (newest at back)
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_ras[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST;
    m_valid = 1'b0;
    m_ras.delete();
  endtask

  function automatic logic [2:0] m_count();
`ifdef PC_GEN_RAS_EN
    return 3'(m_ras.size());
`else
    return 3'd0;
`endif
  endfunction

  task automatic model_edge();
    logic [31:0] nxt;
    logic [31:0] p4;
    p4 = m_pc + 32'd4;
    if (!m_valid) begin
      m_valid = 1'b1;
      return;
    end
    if (DD_trap_i) begin
      m_pc = DD_trap_target_i;
      m_ras.delete();
    end else if (DD_mret_i) begin
      m_pc = DD_mret_target_i;
    end else if (DD_mispred_i || DD_jalr_i) begin
      m_pc = DD_jmp_i;
    end else if (F_ready_i) begin
      nxt = F_pred_taken_i ? F_pred_target_i : p4;
`ifdef PC_GEN_RAS_EN
      if (F_is_ret_i && m_ras.size() > 0) begin
        nxt = m_ras[m_ras.size()-1];
        if (F_is_call_i) m_ras[m_ras.size()-1] = p4;
        else void'(m_ras.pop_back());
      end else if (F_is_call_i) begin
        m_ras.push_back(p4);
        if (m_ras.size() > D) void'(m_ras.pop_front());
      end
`endif
      m_pc = nxt;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"}, F_PC_o, m_pc);
    chk({tag, ".valid"}, {31'd0, F_valid_o}, {31'd0, m_valid});
    chk({tag, ".count"}, {29'd0, F_ras_count_o}, {29'd0, m_count()});
  endtask

  // Inputs are stable across the edge; outputs are sampled 1 time unit after it
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    DD_trap_i = 0; DD_mret_i = 0; DD_mispred_i = 0; DD_jalr_i = 0;
    DD_trap_target_i = '0; DD_mret_target_i = '0; DD_jmp_i = '0;
    F_ready_i = 0; F_pred_taken_i = 0; F_pred_target_i = '0;
    F_is_call_i = 0; F_is_ret_i = 0;
  endtask

  initial begin
    logic [31:0] ret_exp [5];
    logic [31:0] hold_pc;
    logic [2:0]  hold_cnt;
    idle_inputs();
    model_reset();

    // Reset held: outputs forced, trap ignored
    DD_trap_i = 1; DD_trap_target_i = 32'h1234_5670; F_ready_i = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, F_valid_o}, 32'd0);
    chk("rst.pc", F_PC_o, RST);
    chk("rst.count", {29'd0, F_ras_count_o}, 32'd0);

    // Release; the trap still asserted on the first edge must be ignored
    rst_n = 1;
    step("first_edge");
    chk("first_edge.pc_const", F_PC_o, 32'h8000_0000);
    DD_trap_i = 0;
    step("seq1");
    chk("seq1.pc_const", F_PC_o, 32'h8000_0004);
    step("seq2");
    chk("seq2.pc_const", F_PC_o, 32'h8000_0008);

    // Trap beats mispredict regardless of ready
    F_ready_i = 0; DD_mispred_i = 1; DD_jmp_i = 32'h8000_0100;
    DD_trap_i = 1; DD_trap_target_i = 32'h8000_0040;
    step("trap_prio");
    chk("trap_prio.pc_const", F_PC_o, 32'h8000_0040);
    chk("trap_prio.count_const", {29'd0, F_ras_count_o}, 32'd0);
    idle_inputs();

    // Wrap of PC+4
    DD_mret_i = 1; DD_mret_target_i = 32'hFFFF_FFFC;
    step("mret");
    idle_inputs(); F_ready_i = 1;
    step("wrap");
    chk("wrap.pc_const", F_PC_o, 32'h0000_0000);

    // Call then return
    idle_inputs(); DD_jalr_i = 1; DD_jmp_i = 32'h8000_0010;
    step("jalr");
    idle_inputs(); F_ready_i = 1; F_is_call_i = 1; F_pred_taken_i = 1; F_pred_target_i = 32'h8000_0200;
    step("call");
    idle_inputs(); F_ready_i = 1; F_is_ret_i = 1;
    step("ret");
`ifdef PC_GEN_RAS_EN
    chk("ret.pc_const", F_PC_o, 32'h8000_0014);
    chk("ret.count_const", {29'd0, F_ras_count_o}, 32'd0);
`endif

    // Five calls then five returns (overflow wraps onto the oldest entry)
    idle_inputs(); DD_jalr_i = 1; DD_jmp_i = 32'h8000_0014;
    step("jalr2");
    idle_inputs(); F_ready_i = 1; F_is_call_i = 1;
    for (int i = 0; i < 5; i++) begin
      step("call5");
      chk("call5.count_le_depth", {31'd0, F_ras_count_o <= 3'd4}, 32'd1);
    end
    ret_exp = '{32'h8000_0028, 32'h8000_0024, 32'h8000_0020, 32'h8000_001C, 32'h8000_0020};
    F_is_call_i = 0; F_is_ret_i = 1;
    for (int i = 0; i < 5; i++) begin
      step("ret5");
`ifdef PC_GEN_RAS_EN
      chk("ret5.pc_const", F_PC_o, ret_exp[i]);
`endif
    end

    // Stall: PC and stack frozen, hints ignored
    idle_inputs(); F_ready_i = 1; F_is_call_i = 1;
    step("push_before_stall");
    hold_pc = F_PC_o; hold_cnt = F_ras_count_o;
    F_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      F_is_call_i = 1'($urandom); F_is_ret_i = 1'($urandom); F_pred_taken_i = 1'($urandom);
      step("stall");
      chk("stall.pc_hold", F_PC_o, hold_pc);
      chk("stall.cnt_hold", {29'd0, F_ras_count_o}, {29'd0, hold_cnt});
    end

    // Random traffic with an asynchronous reset dropped in mid-stream
    for (int i = 0; i < 400; i++) begin
      DD_trap_i        = ($urandom_range(0, 24) == 0);
      DD_mret_i        = ($urandom_range(0, 24) == 0);
      DD_mispred_i     = ($urandom_range(0, 12) == 0);
      DD_jalr_i        = ($urandom_range(0, 12) == 0);
      DD_trap_target_i = $urandom & 32'hFFFF_FFFC;
      DD_mret_target_i = $urandom & 32'hFFFF_FFFC;
      DD_jmp_i         = $urandom & 32'hFFFF_FFFC;
      F_ready_i        = ($urandom_range(0, 3) != 0);
      F_pred_taken_i   = ($urandom_range(0, 3) == 0);
      F_pred_target_i  = $urandom & 32'hFFFF_FFFC;
      F_is_call_i      = ($urandom_range(0, 2) == 0);
      F_is_ret_i       = ($urandom_range(0, 2) == 0);
      step("rand");
      if (i == 200) begin
        rst_n = 0;
        #1;
        model_reset();
        check_model("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
